// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op and state
// encodings, the iteration count, and small two's-complement helpers.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  localparam int MD_ITER = 32;

  // Two's-complement negation of a 32-bit value.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return 32'd0 - v;
  endfunction

  // Magnitude of a value interpreted as signed; 32'h8000_0000 maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    logic [31:0] r;
    if (v[31]) begin
      r = neg32(v);
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/muldiv.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Works on operand magnitudes with one shared 33-bit adder/subtractor and a
// 64-bit working register; signs are applied in a final FIX cycle.
module muldiv
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [5:0] LAST_CNT = 6'(MD_ITER - 1);

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic [63:0] acc_q;       // {rem, quo} for divide, {acc_hi, acc_lo} for multiply
  logic [31:0] opnd_q;      // multiplicand or divisor magnitude
  logic        is_div_q;
  logic        neg_quo_q;   // sign of product / quotient
  logic        neg_rem_q;   // sign of remainder
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        signed_op_s;
  logic        div_op_s;
  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;

  logic [32:0] add_a_s;
  logic [32:0] add_b_s;
  logic [32:0] add_res_s;
  logic [63:0] acc_d;

  logic [63:0] prod_fix_s;
  logic [31:0] res_hi_d;
  logic [31:0] res_lo_d;

  // Decode the requested op and form operand magnitudes for launch.
  always_comb begin
    signed_op_s = (op == OP_MULT) || (op == OP_DIV);
    div_op_s    = (op == OP_DIV) || (op == OP_DIVU);
    if (signed_op_s) begin
      mag_a_s = abs32(A);
      mag_b_s = abs32(B);
    end else begin
      mag_a_s = A;
      mag_b_s = B;
    end
  end

  // One iteration: shift-add for multiply, restoring trial subtract for divide.
  // The shifted remainder is always below twice the divisor, so bit 32 of the
  // 33-bit difference is exactly the borrow.
  always_comb begin
    add_b_s = {1'b0, opnd_q};
    if (is_div_q) begin
      add_a_s   = acc_q[63:31];
      add_res_s = add_a_s - add_b_s;
      if (!add_res_s[32]) begin
        acc_d = {add_res_s[31:0], acc_q[30:0], 1'b1};
      end else begin
        acc_d = {acc_q[62:0], 1'b0};
      end
    end else begin
      add_a_s   = {1'b0, acc_q[63:32]};
      add_res_s = add_a_s + add_b_s;
      if (acc_q[0]) begin
        acc_d = {add_res_s, acc_q[31:1]};
      end else begin
        acc_d = {1'b0, acc_q[63:1]};
      end
    end
  end

  // Sign-correct the finished magnitude result into HI/LO values.
  always_comb begin
    if (neg_quo_q) begin
      prod_fix_s = 64'd0 - acc_q;
    end else begin
      prod_fix_s = acc_q;
    end
    if (is_div_q) begin
      if (opnd_q == 32'd0) begin
        res_lo_d = 32'hFFFF_FFFF;
      end else if (neg_quo_q) begin
        res_lo_d = neg32(acc_q[31:0]);
      end else begin
        res_lo_d = acc_q[31:0];
      end
      if (neg_rem_q) begin
        res_hi_d = neg32(acc_q[63:32]);
      end else begin
        res_hi_d = acc_q[63:32];
      end
    end else begin
      res_hi_d = prod_fix_s[63:32];
      res_lo_d = prod_fix_s[31:0];
    end
  end

  // Control FSM, datapath registers and HI/LO architectural state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      acc_q     <= 64'd0;
      opnd_q    <= 32'd0;
      is_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (hi_we) begin
            hi_q <= wdata;
          end
          if (lo_we) begin
            lo_q <= wdata;
          end
          if (start) begin
            is_div_q  <= div_op_s;
            neg_quo_q <= signed_op_s & (A[31] ^ B[31]);
            neg_rem_q <= signed_op_s & A[31];
            cnt_q     <= 6'd0;
            busy_q    <= 1'b1;
            state_q   <= S_RUN;
            if (div_op_s) begin
              acc_q  <= {32'd0, mag_a_s};
              opnd_q <= mag_b_s;
            end else begin
              acc_q  <= {32'd0, mag_b_s};
              opnd_q <= mag_a_s;
            end
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == LAST_CNT) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          hi_q    <= res_hi_d;
          lo_q    <= res_lo_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: directed corner cases plus randomized ops
// compared against a plain-arithmetic HI/LO reference model.
module tb_muldiv;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_tests;
  int          n_fail;
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  muldiv dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural result {HI, LO} computed with ordinary integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: res = 64'(sa * sb);
      2'd1: res = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else            res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  // Launch one op (inputs driven 1 time unit after an edge), optionally with
  // an MTHI in the launch cycle and/or a stray start+MTHI/MTLO during RUN.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inj, input bit mt_start);
    logic [63:0] exp;
    int cyc;
    exp   = ref_result(o, a, b);
    op    = o;
    A     = a;
    B     = b;
    start = 1'b1;
    if (mt_start) begin
      hi_we = 1'b1;
      wdata = 32'hCAFE_0001;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    if (mt_start) begin
      model_hi = 32'hCAFE_0001;
      check_eq("mthi_with_start", {32'd0, hi}, {32'd0, model_hi});
    end
    check_eq("busy_after_start", {63'd0, busy}, 64'd1);
    check_eq("done_low_in_run", {63'd0, done}, 64'd0);
    cyc = 0;
    while (!done && cyc < 40) begin
      if (inj != 0 && cyc == inj) begin
        start = 1'b1;
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        op    = ~o;
        A     = 32'd9;
        B     = 32'd3;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (inj != 0 && cyc == inj + 1) begin
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        check_eq("hi_hold_busy", {32'd0, hi}, {32'd0, model_hi});
        check_eq("lo_hold_busy", {32'd0, lo}, {32'd0, model_lo});
      end
    end
    check_eq("latency", 64'(cyc), 64'd33);
    check_eq("busy_with_done", {63'd0, busy}, 64'd0);
    check_eq("hi_result", {32'd0, hi}, {32'd0, exp[63:32]});
    check_eq("lo_result", {32'd0, lo}, {32'd0, exp[31:0]});
    model_hi = exp[63:32];
    model_lo = exp[31:0];
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    int          sel;
    n_tests  = 0;
    n_fail   = 0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    reset    = 1'b1;
    start    = 1'b0;
    op       = 2'd0;
    A        = 32'd0;
    B        = 32'd0;
    hi_we    = 1'b0;
    lo_we    = 1'b0;
    wdata    = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_hi", {32'd0, hi}, 64'd0);
    check_eq("rst_lo", {32'd0, lo}, 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed results.
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    check_eq("multu_max_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFE);
    check_eq("multu_max_lo", {32'd0, lo}, 64'h0000_0000_0000_0001);
    run_op(2'd0, 32'hFFFF_FFF9, 32'd3, 0, 1'b0);
    check_eq("mult_m7x3", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 0, 1'b0);
    check_eq("mult_min_sq", {hi, lo}, 64'h4000_0000_0000_0000);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    check_eq("div_m7d2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'd3, 32'd100, 32'd7, 0, 1'b0);
    check_eq("divu_100d7", {hi, lo}, {32'd2, 32'd14});
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    check_eq("div_overflow", {hi, lo}, {32'd0, 32'h8000_0000});
    run_op(2'd3, 32'd5, 32'd0, 0, 1'b0);
    check_eq("divu_by0", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    run_op(2'd2, 32'hFFFF_FFF0, 32'd0, 0, 1'b0);
    check_eq("div_by0_neg", {hi, lo}, {32'hFFFF_FFF0, 32'hFFFF_FFFF});

    // MTLO then writes/start while busy are ignored.
    @(posedge clk);
    #1;
    lo_we = 1'b1;
    wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    lo_we = 1'b0;
    model_lo = 32'h1234_5678;
    check_eq("mtlo_visible", {32'd0, lo}, 64'h0000_0000_1234_5678);
    run_op(2'd3, 32'd1000, 32'd33, 5, 1'b0);
    // MTHI in the launch cycle lands, then FIX overwrites it.
    run_op(2'd1, 32'd11, 32'd13, 0, 1'b1);

    // Reset in the middle of a divide.
    op    = 2'd3;
    A     = 32'd123456;
    B     = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_eq("abort_busy", {63'd0, busy}, 64'd0);
    check_eq("abort_done", {63'd0, done}, 64'd0);
    check_eq("abort_hilo", {hi, lo}, 64'd0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    run_op(2'd1, 32'd6, 32'd7, 0, 1'b0);
    check_eq("multu_6x7", {hi, lo}, 64'd42);

    // Randomized back-to-back ops.
    for (int i = 0; i < 60; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      sel  = $urandom_range(0, 7);
      case (sel)
        0:       r_b = 32'd0;
        1:       r_b = 32'($urandom_range(1, 15));
        2: begin
          r_a = 32'h8000_0000;
          r_b = 32'hFFFF_FFFF;
        end
        3:       r_b = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
        default: r_b = $urandom;
      endcase
      run_op(r_op, r_a, r_b, 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
